bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
- 4-digit BCD counter stepping once per prescaled tick, up or down, with three push-button controls: direction toggle, speed toggle (slow/fast) and pause toggle.
- Each button passes through its own synchroniser, debouncer and press detector.
- Outputs packed BCD for the display scanner, plus status flags for LEDs.

Parameters:
DBNC_CYCLES, 1_000_000, clk cycles a synchronised button level must hold before it is accepted (20 ms at 50 MHz); must be >= 2
SLOW_DIV, 50_000_000, clk cycles per count step in slow mode (1 Hz at 50 MHz); must be >= 2
FAST_DIV, 12_500_000, clk cycles per count step in fast mode (4 Hz at 50 MHz); must be >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset; 0 = reset asserted
btn_ud  in  1  raw direction button, active-high, asynchronous to clk
btn_speed  in  1  raw speed button, active-high, asynchronous to clk
btn_pause  in  1  raw pause button, active-high, asynchronous to clk
bcd  out  16  count value; [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units
dir  out  1  1 = counting up, 0 = counting down
fast  out  1  1 = FAST_DIV period, 0 = SLOW_DIV period
paused  out  1  1 = counting halted
tick  out  1  one-cycle pulse in the cycle bcd is updated

Behaviour:
- Reset (reset=0, async): bcd=16'h0000, dir=1, fast=0, paused=0, tick=0, prescaler=0, all synchronisers/debouncers=0, no pending press events.
- Button path, per button, identical and independent:
  - 2-FF synchroniser.
  - Debouncer: stable state changes only after the synchronised level differs from it for DBNC_CYCLES consecutive cycles. Any reversion clears the run counter.
  - Press event: 1-cycle pulse on a 0->1 transition of the stable state. Releases produce no event.
  - Press-to-effect latency: 2 + DBNC_CYCLES + 1 cycles from raw edge to flag change.
- Press events, each applied the cycle after the pulse:
  - ud toggles dir.
  - speed toggles fast and clears the prescaler to 0.
  - pause toggles paused.
  - Simultaneous events in one cycle are all applied.
- Prescaler:
  - When paused=0, counts 0..DIV-1, where DIV = fast ? FAST_DIV : SLOW_DIV.
  - At DIV-1 it returns to 0 and tick=1 for that cycle.
  - When paused=1, holds its value and tick=0. Resuming continues from the held value, so no step is lost or duplicated.
  - If fast toggles while the prescaler is above the new DIV-1, the speed-event clear takes precedence.
- Count step on tick:
  - Up: units +1. A digit at 9 becomes 0 and carries to the next digit. 9999 -> 0000.
  - Down: units -1. A digit at 0 becomes 9 and borrows from the next digit. 0000 -> 9999.
  - Each digit always stays in 0..9.
  - Event and tick in the same cycle: the step uses the pre-event dir; the new dir applies from the next tick.
- bcd is registered and changes only in a tick cycle.

Optional Feature:
- Macro BCD_SATURATE_EN.
- Defined:
  - Up at 9999 holds 9999; down at 0000 holds 0000.
  - tick still pulses.
  - An extra output wrap_block (1 bit) is 1 while bcd sits at the limit in the current direction. Reset value 0.
- Undefined: wrap-around as above and no wrap_block port.

Test Plan:
Bench parameters for all scenarios: DBNC_CYCLES=4, SLOW_DIV=10, FAST_DIV=3.
1. Release reset, no buttons -> bcd=0000 after reset; first tick 10 cycles later with bcd=0001; bcd=0010 after 100 cycles; all digits <=9.
2. Press btn_ud with a 3-cycle glitch, then a clean 10-cycle press -> glitch ignored; dir 1->0 exactly 7 cycles after the clean edge; from 0002 the next ticks give 0001, 0000, 9999, 9998.
3. Press btn_speed -> fast=1, prescaler cleared; ticks every 3 cycles. Press again -> fast=0, ticks every 10 cycles.
4. Press btn_pause mid-period with prescaler=6 -> paused=1, no tick, bcd frozen for 50 cycles. Press again -> next tick exactly 4 cycles after resume.
5. Preload to 9999 via ticks with dir=1 -> next tick gives 0000 (with BCD_SATURATE_EN: stays 9999 and wrap_block=1). Assert reset=0 mid-count -> all outputs return to reset values immediately.
6. Press btn_ud and btn_speed together so both events coincide with a tick -> step uses the old direction; dir and fast both toggle; next tick comes 3 cycles later and uses the new direction.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: 4-digit BCD up/down counter with debounced direction, speed and pause buttons.
// Define BCD_SATURATE_EN to clamp at 0000/9999 and add the wrap_block output instead of wrapping.
module bcd_updown_counter #(
  parameter int DBNC_CYCLES = 1_000_000,
  parameter int SLOW_DIV    = 50_000_000,
  parameter int FAST_DIV    = 12_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_ud,
  input  logic        btn_speed,
  input  logic        btn_pause,
  output logic [15:0] bcd,
`ifdef BCD_SATURATE_EN
  output logic        wrap_block,
`endif
  output logic        dir,
  output logic        fast,
  output logic        paused,
  output logic        tick
);
  localparam int DW = $clog2(DBNC_CYCLES);
  localparam int PW = $clog2(SLOW_DIV > FAST_DIV ? SLOW_DIV : FAST_DIV);
  logic [2:0]         raw, s1_q, s2_q, stab_q, press_q, flip;
  logic [2:0][DW-1:0] run_q, run_d;
  logic [PW-1:0]      pre_q, pre_d, last;
  logic [15:0]        bcd_q, bcd_d, nxt;
  logic [3:0]         dig;
  logic               cy, dir_q, fast_q, paused_q, tick_q, tick_d;
  assign raw = {btn_pause, btn_speed, btn_ud};
  // A level is accepted on the DBNC_CYCLES-th consecutive differing sample; any match restarts the run.
  always_comb begin
    run_d = '0;
    flip  = '0;
    for (int i = 0; i < 3; i++) begin
      flip[i]  = (s2_q[i] != stab_q[i]) && (run_q[i] == DW'(DBNC_CYCLES - 1));
      run_d[i] = (s2_q[i] == stab_q[i] || flip[i]) ? '0 : run_q[i] + 1'b1;
    end
  end
  assign last   = fast_q ? PW'(FAST_DIV - 1) : PW'(SLOW_DIV - 1);
  assign tick_d = ~paused_q & (pre_q == last);
  assign pre_d  = (press_q[1] | tick_d) ? '0 : paused_q ? pre_q : pre_q + 1'b1;
  // Ripple carry/borrow through the digits; cy ends high when every digit sat at the limit.
  always_comb begin
    nxt = bcd_q;
    dig = '0;
    cy  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dig = bcd_q[4*i +: 4];
      nxt[4*i +: 4] = !cy ? dig :
                      dir_q ? (dig == 4'd9 ? 4'd0 : dig + 4'd1) :
                              (dig == 4'd0 ? 4'd9 : dig - 4'd1);
      cy = cy & (dir_q ? dig == 4'd9 : dig == 4'd0);
    end
  end
`ifdef BCD_SATURATE_EN
  assign bcd_d      = (tick_d && !cy) ? nxt : bcd_q;
  assign wrap_block = cy;
`else
  assign bcd_d = tick_d ? nxt : bcd_q;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stab_q   <= '0;
      press_q  <= '0;
      run_q    <= '0;
      pre_q    <= '0;
      bcd_q    <= '0;
      dir_q    <= 1'b1;
      fast_q   <= 1'b0;
      paused_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stab_q   <= stab_q ^ flip;
      press_q  <= flip & ~stab_q;
      run_q    <= run_d;
      pre_q    <= pre_d;
      bcd_q    <= bcd_d;
      tick_q   <= tick_d;
      dir_q    <= dir_q ^ press_q[0];
      fast_q   <= fast_q ^ press_q[1];
      paused_q <= paused_q ^ press_q[2];
    end
  assign bcd    = bcd_q;
  assign dir    = dir_q;
  assign fast   = fast_q;
  assign paused = paused_q;
  assign tick   = tick_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed stimulus with an integer-arithmetic reference model checked every cycle.
module tb_bcd_updown_counter;
  localparam int DBNC = 4, SLOW = 10, FAST = 3;
`ifdef BCD_SATURATE_EN
  localparam logic [15:0] LOW_WRAP = 16'h0000, UP_WRAP = 16'h0001;
`else
  localparam logic [15:0] LOW_WRAP = 16'h9999, UP_WRAP = 16'h0000;
`endif
  logic clk = 1'b0, reset = 1'b1, btn_ud = 1'b0, btn_speed = 1'b0, btn_pause = 1'b0;
  logic [15:0] bcd;
  logic dir, fast, paused, tick;
  int total = 0, bad = 0;
  int m_bcd = 0, m_pre = 0;
  logic m_dir = 1'b1, m_fast = 1'b0, m_paused = 1'b0, m_tick = 1'b0;
  logic [2:0] s1 = '0, s2 = '0, stab = '0, ev = '0;
  logic [DBNC-1:0] hist [3];
`ifdef BCD_SATURATE_EN
  logic wrap_block;
`endif

  bcd_updown_counter #(.DBNC_CYCLES(DBNC), .SLOW_DIV(SLOW), .FAST_DIV(FAST)) dut (
    .clk(clk), .reset(reset), .btn_ud(btn_ud), .btn_speed(btn_speed), .btn_pause(btn_pause),
`ifdef BCD_SATURATE_EN
    .wrap_block(wrap_block),
`endif
    .bcd(bcd), .dir(dir), .fast(fast), .paused(paused), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int step(input int v, input logic up);
`ifdef BCD_SATURATE_EN
    return up ? (v == 9999 ? v : v + 1) : (v == 0 ? 0 : v - 1);
`else
    return up ? (v + 1) % 10000 : (v + 9999) % 10000;
`endif
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_step();
    int div;
    logic [2:0] raw;
    raw = {btn_pause, btn_speed, btn_ud};
    if (!reset) begin
      m_bcd = 0; m_pre = 0; m_dir = 1'b1; m_fast = 1'b0; m_paused = 1'b0; m_tick = 1'b0;
      s1 = '0; s2 = '0; stab = '0; ev = '0;
      for (int b = 0; b < 3; b++) hist[b] = '0;
    end else begin
      div = m_fast ? FAST : SLOW;
      m_tick = !m_paused && m_pre == div - 1;
      if (m_tick) m_bcd = step(m_bcd, m_dir);
      m_pre = (ev[1] || m_tick) ? 0 : m_paused ? m_pre : m_pre + 1;
      m_dir = m_dir ^ ev[0];
      m_fast = m_fast ^ ev[1];
      m_paused = m_paused ^ ev[2];
      for (int b = 0; b < 3; b++) begin
        hist[b] = {hist[b][DBNC-2:0], s2[b]};
        ev[b] = 1'b0;
        if (hist[b] == {DBNC{~stab[b]}}) begin
          ev[b] = ~stab[b];
          stab[b] = ~stab[b];
        end
      end
      s2 = s1;
      s1 = raw;
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("bcd", bcd, to_bcd(m_bcd));
    chk("dir", 16'(dir), 16'(m_dir));
    chk("fast", 16'(fast), 16'(m_fast));
    chk("paused", 16'(paused), 16'(m_paused));
    chk("tick", 16'(tick), 16'(m_tick));
`ifdef BCD_SATURATE_EN
    chk("wrap_block", 16'(wrap_block), 16'(m_dir ? m_bcd == 9999 : m_bcd == 0));
`endif
  end

  task automatic measure_gap(output int gap);
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 40) begin cyc(1); n++; end
    gap = 0;
    do begin cyc(1); gap++; end while (tick !== 1'b1 && gap < 40);
  endtask

  initial begin
    int gap, n;
    #3 reset = 1'b0;
    cyc(2);
    chk("rst bcd", bcd, 16'h0000);
    chk("rst dir", 16'(dir), 16'd1);
    chk("rst fast", 16'(fast), 16'd0);
    chk("rst paused", 16'(paused), 16'd0);
    chk("rst tick", 16'(tick), 16'd0);
    reset = 1'b1;
    cyc(10);
    chk("first tick", 16'(tick), 16'd1);
    chk("first bcd", bcd, 16'h0001);
    cyc(10);
    btn_ud = 1'b1;
    cyc(3);
    btn_ud = 1'b0;
    cyc(77);
    chk("bcd after 100", bcd, 16'h0010);
    chk("dir after glitch", 16'(dir), 16'd1);
    btn_speed = 1'b1;
    cyc(6);
    chk("fast before", 16'(fast), 16'd0);
    cyc(1);
    chk("fast on", 16'(fast), 16'd1);
    cyc(3);
    btn_speed = 1'b0;
    measure_gap(gap);
    chk("fast gap", 16'(gap), 16'd3);
    cyc(6);
    btn_speed = 1'b1;
    cyc(7);
    chk("fast off", 16'(fast), 16'd0);
    cyc(3);
    btn_speed = 1'b0;
    measure_gap(gap);
    chk("slow gap", 16'(gap), 16'd10);
    cyc(9);
    btn_pause = 1'b1;
    cyc(7);
    chk("paused on", 16'(paused), 16'd1);
    cyc(3);
    btn_pause = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin cyc(1); if (tick === 1'b1) n++; end
    chk("ticks while paused", 16'(n), 16'd0);
    btn_pause = 1'b1;
    cyc(6);
    chk("still paused", 16'(paused), 16'd1);
    cyc(1);
    chk("resumed", 16'(paused), 16'd0);
    cyc(3);
    chk("no early tick", 16'(tick), 16'd0);
    cyc(1);
    chk("resume tick", 16'(tick), 16'd1);
    btn_pause = 1'b0;
    cyc(3);
    btn_ud = 1'b1;
    btn_speed = 1'b1;
    cyc(6);
    chk("pre dir", 16'(dir), 16'd1);
    chk("pre fast", 16'(fast), 16'd0);
    chk("pre tick", 16'(tick), 16'd0);
    cyc(1);
    chk("coincide tick", 16'(tick), 16'd1);
    chk("coincide dir", 16'(dir), 16'd0);
    chk("coincide fast", 16'(fast), 16'd1);
    cyc(3);
    chk("next fast tick", 16'(tick), 16'd1);
    btn_ud = 1'b0;
    btn_speed = 1'b0;
    reset = 1'b0;
    #1;
    chk("async bcd", bcd, 16'h0000);
    chk("async dir", 16'(dir), 16'd1);
    chk("async fast", 16'(fast), 16'd0);
    chk("async paused", 16'(paused), 16'd0);
    chk("async tick", 16'(tick), 16'd0);
    cyc(3);
    reset = 1'b1;
    btn_ud = 1'b1;
    cyc(4);
    btn_ud = 1'b0;
    cyc(3);
    chk("dir down", 16'(dir), 16'd0);
    cyc(3);
    chk("down wrap tick", 16'(tick), 16'd1);
    chk("down wrap bcd", bcd, LOW_WRAP);
    btn_ud = 1'b1;
    cyc(4);
    btn_ud = 1'b0;
    cyc(3);
    chk("dir up", 16'(dir), 16'd1);
    cyc(3);
    chk("up wrap tick", 16'(tick), 16'd1);
    chk("up wrap bcd", bcd, UP_WRAP);
    cyc(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
